// File: rtl/qpsk_tx_fir.sv
// QPSK transmit pulse shaper: bit -> +/-1 symbol, 4x oversampled polyphase RRC FIR.
// Optional QPSK_TX_PRBS_EN replaces tx_in with an internal PRBS9 (x^9+x^5+1) source.
module qpsk_tx_fir #(
  parameter int N_TAPS = 24,
  parameter int OS     = 4,
  parameter int N_SYM  = 6,
  parameter int COEF_W = 8,
  parameter int OUT_W  = 9,
  parameter logic [N_TAPS*COEF_W-1:0] COEF =
    192'h00FEFF000200FBF5F90A253E483E250AF9F5FB000200FFFE,
  parameter logic [8:0] SEED = 9'h1AA
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             tx_in,
  output logic [OUT_W-1:0] tx_out
);

  localparam int PH_W  = $clog2(OS);
  localparam int ACC_W = 11;
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 <<< (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(1 <<< (OUT_W - 1)));

  logic [PH_W-1:0]          r_phase;
  logic signed [1:0]        r_sym  [N_SYM];
  logic signed [1:0]        w_symn [N_SYM];
  logic signed [COEF_W-1:0] w_tap;
  logic signed [ACC_W-1:0]  w_tapx;
  logic signed [ACC_W-1:0]  w_acc;
  logic [OUT_W-1:0]         w_sat;
  logic                     w_bit;
  logic                     w_capture;

  // C[0] lives in the most significant byte of COEF.
  function automatic logic signed [COEF_W-1:0] tap(input int unsigned idx);
    return COEF[(N_TAPS - 1 - int'(idx)) * COEF_W +: COEF_W];
  endfunction

  assign w_capture = enable && (r_phase == '0);

`ifdef QPSK_TX_PRBS_EN
  logic [8:0] r_prbs;
  logic       w_unused_tx_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prbs <= SEED;
    end else if (w_capture) begin
      r_prbs <= {r_prbs[7:0], r_prbs[8] ^ r_prbs[4]};
    end
  end

  assign w_bit          = r_prbs[8];
  assign w_unused_tx_in = tx_in;
`else
  localparam logic [8:0] unused_seed = SEED;

  assign w_bit = tx_in;
`endif

  // Symbol vector as it will be after this edge; the new symbol enters the sum immediately.
  always_comb begin
    for (int unsigned k = 0; k < N_SYM; k++) begin
      w_symn[k] = r_sym[k];
    end
    if (r_phase == '0) begin
      w_symn[0] = w_bit ? 2'sb11 : 2'sb01;
      for (int unsigned k = 1; k < N_SYM; k++) begin
        w_symn[k] = r_sym[k-1];
      end
    end
  end

  // Each product is just add, subtract or skip of the selected polyphase tap.
  always_comb begin
    w_acc  = '0;
    w_tap  = '0;
    w_tapx = '0;
    for (int unsigned k = 0; k < N_SYM; k++) begin
      w_tap  = tap(k * OS + 32'(r_phase));
      w_tapx = {{(ACC_W - COEF_W){w_tap[COEF_W-1]}}, w_tap};
      if (w_symn[k] == 2'sb01) begin
        w_acc = w_acc + w_tapx;
      end else if (w_symn[k] == 2'sb11) begin
        w_acc = w_acc - w_tapx;
      end
    end
  end

  always_comb begin
    w_sat = w_acc[OUT_W-1:0];
    if (w_acc > SAT_MAX) begin
      w_sat = SAT_MAX[OUT_W-1:0];
    end else if (w_acc < SAT_MIN) begin
      w_sat = SAT_MIN[OUT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase <= '0;
      for (int unsigned k = 0; k < N_SYM; k++) begin
        r_sym[k] <= '0;
      end
      tx_out <= '0;
    end else if (enable) begin
      r_phase <= (r_phase == PH_W'(OS - 1)) ? '0 : r_phase + 1'b1;
      for (int unsigned k = 0; k < N_SYM; k++) begin
        r_sym[k] <= w_symn[k];
      end
      tx_out <= w_sat;
    end
  end

endmodule

// File: tb/tb_qpsk_tx_fir.sv
// Directed bench for qpsk_tx_fir: reset, single symbol, constant +/-1, enable gating,
// mid-stream reset and the SEED bit pattern against a convolution model.
module tb_qpsk_tx_fir;

  logic              clk    = 1'b0;
  logic              rst    = 1'b1;
  logic              enable = 1'b0;
  logic              tx_in  = 1'b0;
  logic signed [8:0] tx_out;

  int checks = 0;
  int errors = 0;

  int coef [24] = '{0, -2, -1, 0, 2, 0, -5, -11, -7, 10, 37, 62,
                    72, 62, 37, 10, -7, -11, -5, 0, 2, 0, -1, -2};
  int steady [4] = '{62, 59, 62, 59};
  int hist [6];
  logic [8:0] m_lfsr;
  logic       m_bit;
  int         m_exp;

  always #5 clk = ~clk;

  qpsk_tx_fir dut (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .tx_in  (tx_in),
    .tx_out (tx_out)
  );

  task automatic step(input logic en, input logic b, input int exp, input string tag,
                      input bit chk);
    logic signed [8:0] e;
    enable = en;
    tx_in  = b;
    @(posedge clk);
    #1;
    if (chk) begin
      e = 9'(exp);
      checks++;
      assert (tx_out === e) else begin
        errors++;
        $error("FAIL %s: got %0d expected %0d", tag, tx_out, e);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b1, 1'($urandom_range(0, 1)), 0, "reset_hold", 1'b1);
    rst = 1'b0;
    step(1'b0, 1'b1, 0, "post_reset_idle", 1'b1);
    step(1'b0, 1'b0, 0, "post_reset_idle", 1'b1);

`ifndef QPSK_TX_PRBS_EN
    step(1'b1, 1'b0,  0, "single_p0", 1'b1);
    step(1'b1, 1'b1, -2, "single_p1", 1'b1);
    step(1'b1, 1'b1, -1, "single_p2", 1'b1);
    step(1'b1, 1'b1,  0, "single_p3", 1'b1);
    step(1'b0, 1'b1,  0, "single_hold", 1'b1);

    for (int s = 0; s < 7; s++)
      for (int p = 0; p < 4; p++)
        step(1'b1, 1'b0, steady[p], "const_pos", s == 6);

    step(1'b1, 1'b0, 62, "gate_pre_p0", 1'b1);
    step(1'b1, 1'b0, 59, "gate_pre_p1", 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 59, "gate_hold", 1'b1);
    step(1'b1, 1'b0, 62, "gate_resume_p2", 1'b1);
    step(1'b1, 1'b0, 59, "gate_resume_p3", 1'b1);

    step(1'b1, 1'b1, 62, "neg_edge_p0", 1'b1);
    step(1'b1, 1'b1, 63, "neg_edge_p1", 1'b1);
    step(1'b1, 1'b1, 64, "neg_edge_p2", 1'b1);
    step(1'b1, 1'b1, 59, "neg_edge_p3", 1'b1);
    for (int s = 0; s < 6; s++)
      for (int p = 0; p < 4; p++)
        step(1'b1, 1'b1, -steady[p], "const_neg", s == 5);

    rst = 1'b1;
    step(1'b1, 1'b1, 0, "reset_mid", 1'b1);
    rst = 1'b0;
    step(1'b1, 1'b0,  0, "no_residue_p0", 1'b1);
    step(1'b1, 1'b0, -2, "no_residue_p1", 1'b1);
    step(1'b1, 1'b0, -1, "no_residue_p2", 1'b1);
    step(1'b1, 1'b0,  0, "no_residue_p3", 1'b1);
`endif

    rst = 1'b1;
    step(1'b1, 1'b0, 0, "reset_seed", 1'b1);
    rst = 1'b0;
    m_lfsr = 9'h1AA;
    for (int k = 0; k < 6; k++) hist[k] = 0;
    for (int s = 0; s < 12; s++) begin
      m_bit = m_lfsr[8];
      m_lfsr = {m_lfsr[7:0], m_lfsr[8] ^ m_lfsr[4]};
      for (int k = 5; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = m_bit ? -1 : 1;
      for (int p = 0; p < 4; p++) begin
        m_exp = 0;
        for (int k = 0; k < 6; k++) m_exp += hist[k] * coef[4*k + p];
        step(1'b1, m_bit, m_exp, "seed_pattern", 1'b1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/qpsk_tx_fir.md
Name: qpsk_tx_fir

Overview:
- Baseband transmit pulse-shaping block for the QPSK exercise: one bit per symbol, 4x oversampled, polyphase root-raised-cosine FIR.
- Maps each incoming bit to a +/-1 symbol and holds the last 6 symbols.
- Produces one signed 9-bit filtered sample per enabled clock.
- Sits between the PRBS9 bit source and the DAC/output path.

Parameters:
- COEF, 192'h00FEFF000200FBF5F90A253E483E250AF9F5FB000200FFFE, 24 packed signed 8-bit taps; C[0] = most significant byte, C[23] = least significant byte.
- N_TAPS, 24, number of taps; must equal OS*N_SYM.
- OS, 4, oversampling factor (outputs per symbol).
- N_SYM, 6, symbol history depth (N_TAPS/OS).
- COEF_W, 8, tap width (two's complement).
- OUT_W, 9, output width (two's complement).
- SEED, 9'h1AA, PRBS9 reset seed; used only with the optional feature.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- enable  in  1  clock enable; low = all state and the output hold
- tx_in  in  1  input bit; sampled only on enabled edges with phase==0
- tx_out  out  9  signed filtered sample, registered

Behaviour:
- Single clock domain; reset is synchronous and active-high: on a rising clk edge with rst=1, phase<=0, every symbol register<=0 (zero symbol, not +/-1), tx_out<=0.
- Reset overrides enable and takes effect mid-operation with no residue from prior symbols.
- Bit-to-symbol mapping: tx_in=0 -> +1; tx_in=1 -> -1. Symbols are stored as 2-bit signed values {-1,0,+1}; 0 occurs only after reset.
- Phase counter p, 2 bits, runs 0..OS-1 and wraps 3->0. It advances only on enabled edges.
- On an enabled edge with p==0, the symbol shift happens: sym[0]<=map(tx_in) and sym[k]<=sym[k-1] for k=1..5; sym[5] is discarded.
- On every enabled edge, tx_out <= sum over k=0..5 of symn[k]*C[OS*k+p].
  - symn is the symbol vector being loaded on that edge; the new symbol is included combinationally.
  - Net effect: a symbol captured at edge E contributes C[0..3] at edges E..E+3, C[4..7] at the next symbol period, and so on.
- Latency: 1 clock from the capturing edge to the first affected tx_out value.
- Products are formed as sign selection (add, subtract or skip the tap); no multipliers.
- Accumulator is 11 bits signed. The result saturates to the 9-bit range [-256, +255]. With the default COEF the maximum |sum| is 90, so saturation never triggers.
- enable low: p, symbols and tx_out are all frozen; tx_in is ignored.
- Upstream bit sources must present a new bit once per OS enabled cycles, aligned to p==0.

Optional Feature:
- Macro QPSK_TX_PRBS_EN.
- Defined:
  - An internal PRBS9 generator (x^9+x^5+1) supplies the bit stream and tx_in is ignored.
  - Register r[8:0] resets to SEED; output bit = r[8].
  - On each symbol-capture edge (enabled, p==0), the current r[8] is used as the bit, then r <= {r[7:0], r[8]^r[4]}.
- Undefined: no PRBS logic is built; bits come from tx_in.

Test Plan:
- Reset: rst=1 for 4 clocks with enable=1 and random tx_in -> tx_out=0 throughout. After release, tx_out=0 until the first capture.
- Single symbol: after reset, tx_in=0 for one symbol, then enable low -> tx_out sequence after the first 4 enabled edges is 0, -2, -1, 0 (C[0..3]).
- Constant +1: tx_in=0 for at least 7 symbols -> steady periodic tx_out = 62, 59, 62, 59 for p=0..3.
- Constant -1: tx_in=1 for at least 7 symbols -> steady tx_out = -62, -59, -62, -59.
- Enable gating: drop enable for 5 cycles mid-stream -> tx_out and phase hold. On resume the sequence continues exactly where it left off.
- PRBS (QPSK_TX_PRBS_EN defined): first 9 captured bits equal the SEED bits MSB first (1,1,0,1,0,1,0,1,0) -> tx_out matches the golden model. With the macro undefined, the tx_in stream drives the same values.
